// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// master = operand source plus result sink; slave = the adder pipeline.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage WIDTH-bit adder/subtractor on 4-bit carry-lookahead groups.
// Stage 1 registers bit/group propagate-generate; stage 2 resolves carries and registers sum and flags.
module cla_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    cla_addsub_pipe_if.slave  bus
);
    localparam int NG = WIDTH / 4;

    // Stage-1 next-state values
    logic [WIDTH-1:0]    bx;
    logic [WIDTH-1:0]    p_d;
    logic [WIDTH-1:0]    g_d;
    logic [NG-1:0]       gp_d;
    logic [NG-1:0]       gg_d;
    logic [NG-1:0][2:0]  gl_d;

    // Stage-1 registers; bit-3 generate of each nibble only matters through the group G
    logic [WIDTH-1:0]    s1_p;
    logic [NG-1:0][2:0]  s1_gl;
    logic [NG-1:0]       s1_gp;
    logic [NG-1:0]       s1_gg;
    logic                s1_cin;
    logic                s1_valid;

    // Stage-2 combinational carry resolution
    logic [NG:0]         gc;
    logic [WIDTH-1:0]    cb;
    logic [WIDTH-1:0]    sum_d;
    logic                term;
    logic                carry;

    // Output registers
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q;
    logic                ovf_q;
    logic                zero_q;
    logic                out_valid_q;

    logic                s2_adv;
    logic                in_ready;
    logic                accept;

    assign s2_adv   = s1_valid && (!out_valid_q || bus.out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        bx   = bus.sub ? ~bus.b : bus.b;
        p_d  = bus.a ^ bx;
        g_d  = bus.a & bx;
        gp_d = '0;
        gg_d = '0;
        gl_d = '0;
        for (int k = 0; k < NG; k++) begin
            gp_d[k] = &p_d[4*k +: 4];
            gg_d[k] = g_d[4*k+3]
                    | (p_d[4*k+3] & g_d[4*k+2])
                    | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                    | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
            gl_d[k] = g_d[4*k +: 3];
        end
    end

    // Group carries in flattened sum-of-products form: no carry depends on a lower group carry.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        gc    = '0;
        cb    = '0;
        term  = 1'b0;
        carry = 1'b0;
        gc[0] = s1_cin;
        for (int k = 0; k < NG; k++) begin
            term = s1_cin;
            for (int m = 0; m <= k; m++) term = term & s1_gp[m];
            carry = term;
            for (int j = 0; j <= k; j++) begin
                term = s1_gg[j];
                for (int m = j + 1; m <= k; m++) term = term & s1_gp[m];
                carry = carry | term;
            end
            gc[k+1] = carry;
        end
        for (int k = 0; k < NG; k++) begin
            cb[4*k]   = gc[k];
            cb[4*k+1] = s1_gl[k][0] | (s1_p[4*k] & gc[k]);
            cb[4*k+2] = s1_gl[k][1]
                      | (s1_p[4*k+1] & s1_gl[k][0])
                      | (s1_p[4*k+1] & s1_p[4*k] & gc[k]);
            cb[4*k+3] = s1_gl[k][2]
                      | (s1_p[4*k+2] & s1_gl[k][1])
                      | (s1_p[4*k+2] & s1_p[4*k+1] & s1_gl[k][0])
                      | (s1_p[4*k+2] & s1_p[4*k+1] & s1_p[4*k] & gc[k]);
        end
        sum_d = s1_p ^ cb;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p        <= '0;
            s1_gl       <= '0;
            s1_gp       <= '0;
            s1_gg       <= '0;
            s1_cin      <= 1'b0;
            s1_valid    <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                s1_p     <= p_d;
                s1_gl    <= gl_d;
                s1_gp    <= gp_d;
                s1_gg    <= gg_d;
                s1_cin   <= bus.sub;
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                sum_q       <= sum_d;
                cout_q      <= gc[NG];
                ovf_q       <= cb[WIDTH-1] ^ gc[NG];
                zero_q      <= ~|sum_d;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
